// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter
//
// Collects up to NUM_SRC interrupt lines into the single interrupt request
// seen by the CSR unit. Sources are latched into a pending register and
// masked by an enable register. The lowest-numbered pending, enabled source
// is requested. The request is held until the CSR unit reports the trap was
// taken. After that, no new request is made until mret retires, so there is
// no nesting.
//
// Build option:
//   IRQ_ARB_EDGE_EN  defined   -> rising-edge detection (irq_src & ~src_q)
//                    undefined -> level-sensitive detection (irq_src)
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   irq_src    in   raw source lines, already synchronous to clk
//   irq_taken  in   1-cycle pulse: CSR unit entered the trap
//   irq_done   in   1-cycle pulse: mret retired
//   cfg_wr     in   configuration write strobe
//   cfg_addr   in   0 = ENABLE, 1 = PENDING (W1C), 2 = CLAIM (RO), 3 = reserved
//   cfg_wdata  in   configuration write data
//   cfg_rdata  out  combinational read data for cfg_addr
//   interrupt  out  registered interrupt request
//   irq_id     out  registered ID of the requested / in-service source
// ---------------------------------------------------------------------------
module irq_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic                irq_taken,
    input  logic                irq_done,
    input  logic                cfg_wr,
    input  logic [1:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    output logic                interrupt,
    output logic [ID_W-1:0]     irq_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_SRC-1:0]   r_enable;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_src_q;
    logic                 r_interrupt;
    logic [ID_W-1:0]      r_irq_id;

    logic [NUM_SRC-1:0]   w_detect;
    logic [NUM_SRC-1:0]   w_w1c;
    logic [NUM_SRC-1:0]   w_claim_clr;
    logic [NUM_SRC-1:0]   w_en_nxt;
    logic [NUM_SRC-1:0]   w_pend_nxt;
    logic [NUM_SRC-1:0]   w_cand;
    logic [ID_W-1:0]      w_sel_id;
    logic                 w_withdraw;
    logic                 w_int_nxt;
    logic [ID_W-1:0]      w_id_nxt;
    logic                 w_unused_bits;

`ifdef IRQ_ARB_EDGE_EN
    assign w_detect = irq_src & ~r_src_q;
`else
    assign w_detect = irq_src;
`endif

    // Bits that some configurations never consume (upper write-data bits,
    // src_q in the level build) are gathered here so they stay referenced.
    assign w_unused_bits = ^{cfg_wdata, r_src_q};

    assign w_w1c = (cfg_wr && (cfg_addr == 2'd1)) ? cfg_wdata[NUM_SRC-1:0]
                                                   : {NUM_SRC{1'b0}};

    // The claim clear only happens on the cycle the trap is taken in REQ.
    assign w_claim_clr = ((r_state == ST_REQ) && irq_taken)
                       ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_irq_id)
                       : {NUM_SRC{1'b0}};

    assign w_en_nxt = (cfg_wr && (cfg_addr == 2'd0)) ? cfg_wdata[NUM_SRC-1:0]
                                                      : r_enable;

    // A new detection wins over any clear arriving in the same cycle.
    assign w_pend_nxt = (r_pending & ~(w_w1c | w_claim_clr)) | w_detect;

    assign w_cand = r_pending & r_enable;

    // Withdraw when a cfg write removes either the pending or enable bit of
    // the source currently being requested. Looking at next-state values
    // means a coincident re-detection keeps the request alive.
    assign w_withdraw = ~w_pend_nxt[r_irq_id] | ~w_en_nxt[r_irq_id];

    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        w_sel_id = {ID_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_sel_id = w_cand[i] ? ID_W'(i) : w_sel_id;
        end
    end

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_int_nxt   = r_interrupt;
        w_id_nxt    = r_irq_id;
        case (r_state)
            ST_IDLE: begin
                if (|w_cand) begin
                    w_state_nxt = ST_REQ;
                    w_int_nxt   = 1'b1;
                    w_id_nxt    = w_sel_id;
                end else begin
                    w_int_nxt   = 1'b0;
                end
            end
            ST_REQ: begin
                // A trap taken in the same cycle as a withdrawing write wins.
                if (irq_taken) begin
                    w_state_nxt = ST_SERVICE;
                    w_int_nxt   = 1'b0;
                end else if (w_withdraw) begin
                    w_state_nxt = ST_IDLE;
                    w_int_nxt   = 1'b0;
                end else begin
                    w_int_nxt   = 1'b1;
                end
            end
            ST_SERVICE: begin
                w_int_nxt = 1'b0;
                if (irq_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_int_nxt   = 1'b0;
            end
        endcase
    end

    // State, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_enable    <= {NUM_SRC{1'b0}};
            r_pending   <= {NUM_SRC{1'b0}};
            r_src_q     <= {NUM_SRC{1'b0}};
            r_interrupt <= 1'b0;
            r_irq_id    <= {ID_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_enable    <= w_en_nxt;
            r_pending   <= w_pend_nxt;
            r_src_q     <= irq_src;
            r_interrupt <= w_int_nxt;
            r_irq_id    <= w_id_nxt;
        end
    end

    // Combinational register read mux.
    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0: cfg_rdata[NUM_SRC-1:0] = r_enable;
            2'd1: cfg_rdata[NUM_SRC-1:0] = r_pending;
            2'd2: begin
                cfg_rdata[ID_W-1:0] = r_irq_id;
                cfg_rdata[31]       = (r_state == ST_SERVICE);
            end
            default: cfg_rdata = 32'd0;
        endcase
    end

    assign interrupt = r_interrupt;
    assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_src = 4'd0;
    logic        irq_taken = 1'b0;
    logic        irq_done = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata;
    logic        interrupt;
    logic [1:0]  irq_id;

    int n_vec  = 0;
    int n_miss = 0;

    irq_arbiter #(.NUM_SRC(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .irq_taken (irq_taken),
        .irq_done  (irq_done),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .interrupt (interrupt),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  src;
        logic        tk;
        logic        dn;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        e_int;
        logic [1:0]  e_id;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [3:0] s, logic t, logic d,
                                logic w, logic [1:0] a, logic [31:0] wd,
                                logic ei, logic [1:0] eid, logic [31:0] erd);
        vec_t v;
        v.rst = r; v.src = s; v.tk = t; v.dn = d; v.wr = w; v.addr = a;
        v.wdata = wd; v.e_int = ei; v.e_id = eid; v.e_rd = erd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // rst src tk dn wr addr wdata        int id rdata
        // reset state
        vq.push_back(mk(1, 4'h0, 0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 32'h0));
        vq.push_back(mk(1, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd0, 32'h0));
        // single source
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'h4, 0, 2'd0, 32'h4));
        vq.push_back(mk(0, 4'h4, 0, 0, 0, 2'd1, 32'h0, 0, 2'd0, 32'h4));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd2, 32'h2));
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 2'd2, 32'h0, 0, 2'd2, 32'h8000_0002));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 2'd2, 32'h0, 0, 2'd2, 32'h2));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h0));
        // priority: 3 and 1 together, 1 first; 0 arrives in REQ/SERVICE
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'hF, 0, 2'd2, 32'hF));
        vq.push_back(mk(0, 4'hA, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'hA));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd1, 32'h1));
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 2'd1, 32'h0, 0, 2'd1, 32'h8));
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 2'd1, 32'h0, 0, 2'd1, 32'h8));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd3, 32'h3));
        vq.push_back(mk(0, 4'h1, 0, 0, 0, 2'd1, 32'h0, 1, 2'd3, 32'h9));
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 2'd2, 32'h0, 0, 2'd3, 32'h8000_0003));
        vq.push_back(mk(0, 4'h1, 0, 0, 0, 2'd1, 32'h0, 0, 2'd3, 32'h1));
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 2'd2, 32'h0, 0, 2'd3, 32'h3));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd0, 32'h0));
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 2'd1, 32'h0, 0, 2'd0, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 32'h0));
        // withdraw by ENABLE write
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'h4, 0, 2'd0, 32'h4));
        vq.push_back(mk(0, 4'h4, 0, 0, 0, 2'd1, 32'h0, 0, 2'd0, 32'h4));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd2, 32'h2));
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'h0, 0, 2'd2, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h4));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 0, 2'd2, 32'h2));
        // withdrawing write coincident with taken: taken wins
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'h4, 0, 2'd2, 32'h4));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd2, 32'h2));
        vq.push_back(mk(0, 4'h0, 1, 0, 1, 2'd0, 32'h0, 0, 2'd2, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 0, 2'd2, 32'h8000_0002));
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 2'd1, 32'h0, 0, 2'd2, 32'h0));
        // masking and W1C
        vq.push_back(mk(0, 4'h1, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h1));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h1));
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd1, 32'h1, 0, 2'd2, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'h1, 0, 2'd2, 32'h1));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h0));
        // reserved, ENABLE upper bits, CLAIM write ignored
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd3, 32'hFFFF_FFFF, 0, 2'd2, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'hFFFF_FFF0, 0, 2'd2, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd2, 32'hFFFF_FFFF, 0, 2'd2, 32'h2));
        // reset in the middle of a request
        vq.push_back(mk(0, 4'h0, 0, 0, 1, 2'd0, 32'h8, 0, 2'd2, 32'h8));
        vq.push_back(mk(0, 4'h8, 0, 0, 0, 2'd1, 32'h0, 0, 2'd2, 32'h8));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd2, 32'h0, 1, 2'd3, 32'h3));
        vq.push_back(mk(1, 4'h0, 0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 32'h0));
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 2'd1, 32'h0, 0, 2'd0, 32'h0));

        for (int i = 0; i < vq.size(); i++) begin
            rst       = vq[i].rst;
            irq_src   = vq[i].src;
            irq_taken = vq[i].tk;
            irq_done  = vq[i].dn;
            cfg_wr    = vq[i].wr;
            cfg_addr  = vq[i].addr;
            cfg_wdata = vq[i].wdata;
            step();
            n_vec++;
            if (interrupt !== vq[i].e_int || irq_id !== vq[i].e_id ||
                cfg_rdata !== vq[i].e_rd) begin
                n_miss++;
                $display("FAIL vec%0d: int=%0b id=%0d rdata=%h, expected int=%0b id=%0d rdata=%h",
                         i, interrupt, irq_id, cfg_rdata,
                         vq[i].e_int, vq[i].e_id, vq[i].e_rd);
            end
        end
        rst = 1'b0; irq_src = 4'h0; irq_taken = 1'b0; irq_done = 1'b0;
        cfg_wr = 1'b0; cfg_addr = 2'd0;

        // source 0 held high through a full take/done cycle
        cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h1;
        step();
        cfg_wr = 1'b0;
        irq_src = 4'h1;
        step();
        check("hold_pend_no_int", {31'd0, interrupt}, 32'd0);
        step();
        check("hold_req", {29'd0, interrupt, irq_id}, 32'h4);
        irq_taken = 1'b1; cfg_addr = 2'd2;
        step();
        irq_taken = 1'b0;
        check("hold_taken_int", {31'd0, interrupt}, 32'd0);
        check("hold_claim", cfg_rdata, 32'h8000_0000);
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        check("hold_done_int", {31'd0, interrupt}, 32'd0);
        step();
`ifdef IRQ_ARB_EDGE_EN
        check("hold_rereq", {31'd0, interrupt}, 32'd0);
`else
        check("hold_rereq", {31'd0, interrupt}, 32'd1);
`endif
        step(); step(); step();
`ifdef IRQ_ARB_EDGE_EN
        check("hold_rereq_late", {31'd0, interrupt}, 32'd0);
`else
        check("hold_rereq_late", {31'd0, interrupt}, 32'd1);
`endif
        irq_src = 4'h0; irq_taken = 1'b1;
        step();
        irq_taken = 1'b0; irq_done = 1'b1; cfg_addr = 2'd1;
        step();
        irq_done = 1'b0;
        step();
        check("drain_int", {31'd0, interrupt}, 32'd0);
        check("drain_pending", cfg_rdata, 32'h0);

        // a read in the cycle of a write returns the old value
        cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h2;
        #1;
        check("rd_before_wr_edge", cfg_rdata, 32'h1);
        step();
        cfg_wr = 1'b0;
        check("rd_after_wr_edge", cfg_rdata, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

- Arbitrates up to `NUM_SRC` external interrupt lines into the single `interrupt` request consumed by the CSR unit.
- Latches and masks sources, selects the highest-priority pending enabled source, and holds the request until the CSR unit reports it was taken.
- Blocks further requests until `mret` completes. No nesting.
- Sits between peripheral IRQ lines and the CSR `interrupt` input. `irq_taken` is driven by the CSR trap-taken signal (`csr_epc_taken`); `irq_done` is driven by the M/W-stage `mret` flag.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, legal range 2..32.
- `ID_W`, `$clog2(NUM_SRC)`: width of the source ID.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `irq_src`  in  `NUM_SRC`  raw source lines, assumed already synchronous to `clk`.
- `irq_taken`  in  1  one-cycle pulse from the CSR unit: trap entered.
- `irq_done`  in  1  one-cycle pulse: `mret` retired.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_addr`  in  2  register select: 0 = ENABLE, 1 = PENDING, 2 = CLAIM, 3 = reserved.
- `cfg_wdata`  in  32  write data.
- `cfg_rdata`  out  32  combinational read data for `cfg_addr`.
- `interrupt`  out  1  registered interrupt request to the CSR unit.
- `irq_id`  out  `ID_W`  registered ID of the requested or in-service source.

## Operation
State:
- `enable[NUM_SRC]`
- `pending[NUM_SRC]`
- `src_q[NUM_SRC]`: previous `irq_src`, updated every cycle.
- FSM state, one of IDLE, REQ, SERVICE.

Register map:
- **ENABLE (0):** read/write, bits `[NUM_SRC-1:0]`. Upper bits read 0 and ignore writes.
- **PENDING (1):** read returns `pending`. Write is write-1-to-clear.
- **CLAIM (2):** read-only, `{state==SERVICE, 0…, irq_id}` with `irq_id` in the low bits and the flag in bit 31. Writes ignored.
- **Reserved (3):** reads 0, writes ignored.

Pending update, per bit, each cycle:
- Set term: `detect[i]`, where `detect` is defined under Configuration.
- Clear terms: W1C write to that bit, or claim clear of `irq_id` on `irq_taken` while in REQ.
- When set and clear coincide, set wins.

FSM:
- **IDLE:**
  - Candidate vector `cand = pending & enable`.
  - If `cand` is nonzero: register `irq_id` = lowest set index (index 0 is highest priority), set `interrupt` = 1, go to REQ.
- **REQ:** `interrupt` and `irq_id` are held stable.
  - If `irq_taken`: clear `pending[irq_id]`, set `interrupt` = 0, go to SERVICE.
  - Otherwise, if `pending[irq_id]` or `enable[irq_id]` was cleared by a cfg write: withdraw. Set `interrupt` = 0 and go to IDLE.
  - `irq_taken` in the same cycle as a withdrawing write: taken wins.
  - Higher-priority arrivals do not preempt the current request.
- **SERVICE:**
  - `interrupt` = 0; `irq_id` holds the in-service ID.
  - On `irq_done`, go to IDLE.

Ignored inputs:
- `irq_taken` in IDLE or SERVICE.
- `irq_done` in IDLE or REQ.

## Timing
- Reset values: `enable` = 0, `pending` = 0, `src_q` = 0, state = IDLE, `interrupt` = 0, `irq_id` = 0.
- With reset values, `cfg_rdata` = 0 for all addresses.
- Reset mid-request or mid-service returns to IDLE immediately; `interrupt` = 0 after that edge.
- Latency, source to request: `detect` is captured into `pending` at edge k. `interrupt` rises after edge k+1, i.e. 2 edges from the sampled source.
- `interrupt` falls on the edge that samples `irq_taken`.
- After `irq_done` is sampled at edge m, the next request asserts no earlier than edge m+1 (IDLE evaluates at m+1).
- Back-to-back `irq_done` then `irq_taken` in consecutive cycles is legal.
- A cfg write takes effect at the edge. A read in the same cycle returns the old value.

## Configuration
`IRQ_ARB_EDGE_EN`:
- **Defined (edge-triggered):** `detect = irq_src & ~src_q`. A source must fall and rise again to re-pend. A single edge sets pending exactly once.
- **Undefined (level-sensitive):** `detect = irq_src`. A source still high after its claim re-pends on the next cycle and re-requests after `irq_done`.
- `src_q` exists in both builds; it is unused in the level build.

## Test plan
- **Single source:** reset, ENABLE = 0x4, pulse `irq_src[2]` for one cycle.
  - `interrupt` = 1 two edges later with `irq_id` = 2.
  - `irq_taken` → `interrupt` = 0, CLAIM reads 0x80000002.
  - `irq_done` → IDLE, PENDING = 0.
- **Priority:** ENABLE = 0xF, raise sources 3 and 1 in the same cycle.
  - `irq_id` = 1 first.
  - After `irq_taken` and `irq_done`, `irq_id` = 3 is requested.
  - Source 0 raised during SERVICE waits until IDLE, then wins.
- **Withdraw:** in REQ for ID 2, write ENABLE = 0 → `interrupt` = 0 next edge, state IDLE, PENDING bit 2 still 1.
  - Repeat with `irq_taken` in the same cycle → SERVICE entered.
- **Masking and W1C:** ENABLE = 0, raise source 0 → PENDING = 0x1 and no interrupt.
  - Write PENDING = 0x1 → PENDING = 0.
  - Then ENABLE = 0x1 → no request.
- **Edge vs level:** hold `irq_src[0]` high through a full take/done cycle.
  - With `IRQ_ARB_EDGE_EN`: exactly one request.
  - Without it: a second request asserts 1 edge after `irq_done` is sampled.
- **Reset mid-REQ:** assert `rst` for one cycle while `interrupt` = 1 → `interrupt` = 0, `irq_id` = 0, ENABLE = 0, PENDING = 0.
